// File: rtl/shift_sequencer.sv
// Two-requester sequencer that time-shares one 32-bit logical barrel shifter for SLL/SRL/SRA/ROTR.
// Define SHIFT_ROTATE_EN to build the two-pass rotate; otherwise op 11 executes as SRL.
module shift_sequencer #(
  parameter bit PRIO_INIT = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [31:0] req0_src_i,
  input  logic [4:0]  req0_shamt_i,
  input  logic [1:0]  req0_op_i,

  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [31:0] req1_src_i,
  input  logic [4:0]  req1_shamt_i,
  input  logic [1:0]  req1_op_i,

  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic        rsp_id_o,
  output logic [31:0] rsp_data_o
);

  localparam logic [1:0] OpSll  = 2'b00;
  localparam logic [1:0] OpSrl  = 2'b01;
  localparam logic [1:0] OpSra  = 2'b10;
  localparam logic [1:0] OpRotr = 2'b11;

`ifdef SHIFT_ROTATE_EN
  typedef enum logic [1:0] {StIdle, StPass1, StPass2, StDone} state_e;
`else
  typedef enum logic [1:0] {StIdle, StPass1, StDone} state_e;
`endif

  state_e      state_q, state_d;
  logic        prio_q, prio_d;
  logic [31:0] src_q, src_d;
  logic [4:0]  shamt_q, shamt_d;
  logic [1:0]  op_q, op_d;
  logic        id_q, id_d;
  logic [31:0] result_q, result_d;

  logic        grant_vld;
  logic        grant_id;
  logic        sra_neg;

  // Shared shifter interface
  logic [31:0] sh_src;
  logic [4:0]  sh_amt;
  logic        sh_left;
  logic [31:0] sh_out;

`ifdef SHIFT_ROTATE_EN
  logic [5:0]  rot_amt_full;
  logic [4:0]  rot_amt;

  // Left-pass amount of the rotate: (32 - shamt) mod 32
  assign rot_amt_full = 6'd32 - {1'b0, shamt_q};
  assign rot_amt      = rot_amt_full[4:0];
`endif

  function automatic logic [31:0] bit_rev(input logic [31:0] d);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = d[31-i];
    end
    return r;
  endfunction

  // Logarithmic right shifter; left shifts reuse it by reversing the bit order around it.
  logic [5:0][31:0] stage;

  always_comb begin
    stage[0] = sh_left ? bit_rev(sh_src) : sh_src;
    for (int i = 0; i < 5; i++) begin
      stage[i+1] = sh_amt[i] ? (stage[i] >> (32'd1 << i)) : stage[i];
    end
    sh_out = sh_left ? bit_rev(stage[5]) : stage[5];
  end

  assign grant_vld = req0_valid_i | req1_valid_i;
  assign grant_id  = (req0_valid_i && req1_valid_i) ? prio_q : req1_valid_i;
  assign sra_neg   = (op_q == OpSra) && src_q[31];

  always_comb begin
    state_d      = state_q;
    prio_d       = prio_q;
    src_d        = src_q;
    shamt_d      = shamt_q;
    op_d         = op_q;
    id_d         = id_q;
    result_d     = result_q;
    req0_ready_o = 1'b0;
    req1_ready_o = 1'b0;
    sh_src       = src_q;
    sh_amt       = shamt_q;
    sh_left      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (grant_vld && !rst_i) begin
          req0_ready_o = ~grant_id;
          req1_ready_o = grant_id;
          src_d        = grant_id ? req1_src_i   : req0_src_i;
          shamt_d      = grant_id ? req1_shamt_i : req0_shamt_i;
          op_d         = grant_id ? req1_op_i    : req0_op_i;
          id_d         = grant_id;
          prio_d       = ~grant_id;
          state_d      = StPass1;
        end
      end
      StPass1: begin
        sh_left  = (op_q == OpSll);
        // Arithmetic shift of a negative value: shift the inverse in zeros, invert back.
        sh_src   = sra_neg ? ~src_q : src_q;
        result_d = sra_neg ? ~sh_out : sh_out;
        state_d  = StDone;
`ifdef SHIFT_ROTATE_EN
        if (op_q == OpRotr) begin
          if (shamt_q != 5'd0) begin
            state_d = StPass2;
          end else begin
            result_d = src_q;
          end
        end
`endif
      end
`ifdef SHIFT_ROTATE_EN
      StPass2: begin
        sh_left  = 1'b1;
        sh_amt   = rot_amt;
        result_d = result_q | sh_out;
        state_d  = StDone;
      end
`endif
      StDone: begin
        if (rsp_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      prio_q   <= PRIO_INIT;
      src_q    <= '0;
      shamt_q  <= '0;
      op_q     <= OpSll;
      id_q     <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      src_q    <= src_d;
      shamt_q  <= shamt_d;
      op_q     <= op_d;
      id_q     <= id_d;
      result_q <= result_d;
    end
  end

  assign rsp_valid_o = (state_q == StDone);
  assign rsp_data_o  = result_q;
  assign rsp_id_o    = id_q;

  // OpSrl is the implicit right-shift default; referenced here only to keep the decode table whole.
  logic unused_op;
  assign unused_op = (op_q == OpSrl);

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed, table-driven bench for shift_sequencer; expectations track SHIFT_ROTATE_EN.
module tb_shift_sequencer;

  localparam logic [1:0] OpSll  = 2'b00;
  localparam logic [1:0] OpSrl  = 2'b01;
  localparam logic [1:0] OpSra  = 2'b10;
  localparam logic [1:0] OpRotr = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        v0 = 1'b0, v1 = 1'b0;
  logic        r0, r1;
  logic [31:0] s0 = '0, s1 = '0;
  logic [4:0]  a0 = '0, a1 = '0;
  logic [1:0]  o0 = '0, o1 = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic        rsp_id;
  logic [31:0] rsp_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  shift_sequencer #(.PRIO_INIT(1'b0)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req0_valid_i (v0),
    .req0_ready_o (r0),
    .req0_src_i   (s0),
    .req0_shamt_i (a0),
    .req0_op_i    (o0),
    .req1_valid_i (v1),
    .req1_ready_o (r1),
    .req1_src_i   (s1),
    .req1_shamt_i (a1),
    .req1_op_i    (o1),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_id_o     (rsp_id),
    .rsp_data_o   (rsp_data)
  );

  typedef struct {
    bit          id;
    logic [31:0] src;
    logic [4:0]  shamt;
    logic [1:0]  op;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    v0  = 1'b0;
    v1  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_req(input bit id, input logic [31:0] src, input logic [4:0] shamt,
                         input logic [1:0] op);
    if (id) begin
      v1 = 1'b1; s1 = src; a1 = shamt; o1 = op;
    end else begin
      v0 = 1'b1; s0 = src; a0 = shamt; o0 = op;
    end
  endtask

  // Called at the negedge right after the accept edge; returns the negedge count to rsp_valid.
  task automatic wait_rsp(output int n);
    n = 1;
    while (!rsp_valid && n < 12) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_op(input int idx, input vec_t v);
    int n;
    @(negedge clk);
    rsp_ready = 1'b1;
    set_req(v.id, v.src, v.shamt, v.op);
    #1;
    chk($sformatf("v%0d_ready", idx), 32'(v.id ? r1 : r0), 32'd1);
    chk($sformatf("v%0d_other_ready", idx), 32'(v.id ? r0 : r1), 32'd0);
    @(posedge clk);
    @(negedge clk);
    v0 = 1'b0;
    v1 = 1'b0;
    wait_rsp(n);
    chk($sformatf("v%0d_latency", idx), 32'(n), 32'(v.lat));
    chk($sformatf("v%0d_data", idx), rsp_data, v.exp);
    chk($sformatf("v%0d_id", idx), 32'(rsp_id), 32'(v.id));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int g, r, cyc, last_g;

    vecs[0]  = '{1'b0, 32'h0000_0001, 5'd4,  OpSll,  32'h0000_0010, 2};
    vecs[1]  = '{1'b1, 32'h8000_0000, 5'd4,  OpSra,  32'hF800_0000, 2};
    vecs[2]  = '{1'b1, 32'h7000_0000, 5'd4,  OpSra,  32'h0700_0000, 2};
    vecs[3]  = '{1'b0, 32'h8000_0000, 5'd31, OpSrl,  32'h0000_0001, 2};
    vecs[4]  = '{1'b1, 32'hFFFF_FFFF, 5'd31, OpSll,  32'h8000_0000, 2};
    vecs[5]  = '{1'b0, 32'h8000_0001, 5'd0,  OpSra,  32'h8000_0001, 2};
    vecs[6]  = '{1'b0, 32'hF000_0000, 5'd31, OpSra,  32'hFFFF_FFFF, 2};
    vecs[7]  = '{1'b1, 32'hA5A5_A5A5, 5'd1,  OpSrl,  32'h52D2_D2D2, 2};
    vecs[8]  = '{1'b0, 32'hDEAD_BEEF, 5'd0,  OpRotr, 32'hDEAD_BEEF, 2};
`ifdef SHIFT_ROTATE_EN
    vecs[9]  = '{1'b0, 32'h0000_00F1, 5'd4,  OpRotr, 32'h1000_000F, 3};
    vecs[10] = '{1'b1, 32'h1234_5678, 5'd8,  OpRotr, 32'h7812_3456, 3};
    vecs[11] = '{1'b1, 32'h8000_0000, 5'd31, OpRotr, 32'h0000_0001, 3};
`else
    vecs[9]  = '{1'b0, 32'h0000_00F1, 5'd4,  OpRotr, 32'h0000_000F, 2};
    vecs[10] = '{1'b1, 32'h1234_5678, 5'd8,  OpRotr, 32'h0012_3456, 2};
    vecs[11] = '{1'b1, 32'h8000_0000, 5'd31, OpRotr, 32'h0000_0001, 2};
`endif

    // Reset state
    do_reset();
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_ready0", 32'(r0), 32'd0);
    chk("rst_ready1", 32'(r1), 32'd0);

    for (int i = 0; i < 12; i++) begin
      run_op(i, vecs[i]);
    end

    // Arbitration: both requesters valid continuously, grants alternate from PRIO_INIT=0
    do_reset();
    @(negedge clk);
    rsp_ready = 1'b1;
    set_req(1'b0, 32'h1, 5'd1, OpSll);
    set_req(1'b1, 32'h1, 5'd2, OpSll);
    g = 0; r = 0; cyc = 0; last_g = 0;
    while (r < 4 && cyc < 60) begin
      #1;
      if (r0 || r1) begin
        chk($sformatf("arb_onehot%0d", g), 32'(r0 ^ r1), 32'd1);
        chk($sformatf("arb_grant%0d", g), 32'(r1), 32'(g % 2));
        if (g > 0) chk($sformatf("arb_gap%0d", g), 32'(cyc - last_g), 32'd3);
        last_g = cyc;
        g++;
      end
      if (rsp_valid) begin
        chk($sformatf("arb_rsp_id%0d", r), 32'(rsp_id), 32'(r % 2));
        chk($sformatf("arb_rsp_data%0d", r), rsp_data, (r % 2) ? 32'd4 : 32'd2);
        r++;
      end
      @(negedge clk);
      cyc++;
    end
    v0 = 1'b0;
    v1 = 1'b0;
    chk("arb_rsp_count", 32'(r), 32'd4);
    chk("arb_grant_count", 32'(g), 32'd4);

    // Backpressure: hold DONE for 5 cycles with requester 1 waiting
    @(negedge clk);
    rsp_ready = 1'b0;
    set_req(1'b0, 32'h0000_0100, 5'd4, OpSrl);
    @(posedge clk);
    @(negedge clk);
    v0 = 1'b0;
    set_req(1'b1, 32'h3, 5'd1, OpSll);
    wait_rsp(n);
    chk("bp_latency", 32'(n), 32'd2);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("bp_valid%0d", k), 32'(rsp_valid), 32'd1);
      chk($sformatf("bp_data%0d", k), rsp_data, 32'h0000_0010);
      chk($sformatf("bp_id%0d", k), 32'(rsp_id), 32'd0);
      chk($sformatf("bp_rdy%0d", k), {30'd0, r1, r0}, 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_hs_rdy1", 32'(r1), 32'd0);
    @(negedge clk);
    #1;
    chk("bp_after_valid", 32'(rsp_valid), 32'd0);
    chk("bp_next_grant", 32'(r1), 32'd1);
    @(posedge clk);
    @(negedge clk);
    v1 = 1'b0;
    wait_rsp(n);
    chk("bp2_latency", 32'(n), 32'd2);
    chk("bp2_data", rsp_data, 32'd6);
    chk("bp2_id", 32'(rsp_id), 32'd1);

    // Reset mid-operation, with priority moved away from PRIO_INIT beforehand
    do_reset();
    run_op(100, vecs[0]);
    @(negedge clk);
    rsp_ready = 1'b0;
    set_req(1'b0, 32'h0000_00F1, 5'd4, OpRotr);
    @(posedge clk);
    @(negedge clk);
    v0 = 1'b0;
    @(negedge clk);
`ifdef SHIFT_ROTATE_EN
    chk("mid_pass2_valid", 32'(rsp_valid), 32'd0);
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_data", rsp_data, 32'd0);
    chk("mid_rst_id", 32'(rsp_id), 32'd0);
    chk("mid_rst_rdy", {30'd0, r1, r0}, 32'd0);
    rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("mid_quiet%0d", k), 32'(rsp_valid), 32'd0);
    end
    @(negedge clk);
    set_req(1'b0, 32'h1, 5'd3, OpSll);
    set_req(1'b1, 32'h1, 5'd5, OpSll);
    #1;
    chk("mid_prio_rdy0", 32'(r0), 32'd1);
    chk("mid_prio_rdy1", 32'(r1), 32'd0);
    @(posedge clk);
    @(negedge clk);
    v0 = 1'b0;
    v1 = 1'b0;
    wait_rsp(n);
    chk("mid_post_data", rsp_data, 32'd8);
    chk("mid_post_id", 32'(rsp_id), 32'd0);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
